// File: rtl/aes_byte_loader_if.sv
// Byte-stream / block handshake bundle between the upstream byte source, the
// AES byte loader and the AES core.
interface aes_byte_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   data;
  logic [7:0]   key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_blk;
  logic [127:0] key_blk;
  logic [3:0]   byte_cnt;

  // The loader: consumes the byte stream, produces the assembled blocks.
  modport slave (
    input  in_valid, data, key, out_ready,
    output in_ready, out_valid, state_blk, key_blk, byte_cnt
  );

  // The environment: drives bytes and accepts blocks.
  modport master (
    output in_valid, data, key, out_ready,
    input  in_ready, out_valid, state_blk, key_blk, byte_cnt
  );
endinterface

// File: rtl/aes_byte_loader.sv
// AES-128 input stage: assembles 16 plaintext/key byte pairs into 128-bit
// FIPS-197 blocks and holds them on a valid/ready port until the core takes them.
module aes_byte_loader #(
  parameter bit ROW_MAJOR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  aes_byte_loader_if.slave  bus
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   byte_cnt_q, byte_cnt_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] state_blk_q, state_blk_d;
  logic [127:0] key_blk_q, key_blk_d;

  logic [3:0]   pos;
  logic         in_hs;
  logic         out_hs;

  // Stream index k to FIPS byte index: a pure bit swap, no carries.
  function automatic logic [3:0] lane(input logic [3:0] k);
    return ROW_MAJOR ? {k[1:0], k[3:2]} : k;
  endfunction

  assign pos    = lane(byte_cnt_q);
  assign in_hs  = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    state_blk_d = state_blk_q;
    key_blk_d   = key_blk_q;

    if (clear) begin
      // Abort wins over both handshakes; the block contents are left as-is.
      state_d     = FILL;
      byte_cnt_d  = 4'd0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_hs) begin
            for (int i = 0; i < 16; i++) begin
              if (pos == i[3:0]) begin
                state_blk_d[127-8*i -: 8] = bus.data;
                key_blk_d[127-8*i -: 8]   = bus.key;
              end
            end
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_hs) begin
            state_d     = FILL;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = FILL;
          byte_cnt_d  = 4'd0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: the block registers are reset too, because the outputs must read
  // zero straight out of reset; purely internal storage would not need it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      byte_cnt_q  <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      state_blk_q <= '0;
      key_blk_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      state_blk_q <= state_blk_d;
      key_blk_q   <= key_blk_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_blk = state_blk_q;
  assign bus.key_blk   = key_blk_q;
  assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader: directed FIPS-197 vectors, gaps, hold,
// clear, async reset and back-to-back blocks.
module tb_aes_byte_loader;

  typedef struct {
    logic [127:0] st;
    logic [127:0] ky;
  } blk_t;

  localparam logic [127:0] V1_ST = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1_KY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  // Stream bytes k / A0+k, row-major mapped by hand.
  localparam logic [127:0] V6_ST = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [127:0] V6_KY = 128'ha0a4a8aca1a5a9ada2a6aaaea3a7abaf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  aes_byte_loader_if bif ();

  aes_byte_loader #(.ROW_MAJOR(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  blk_t sb[$];
  int pulses[$];

  logic [7:0] v1_d [16] = '{8'h32, 8'h88, 8'h31, 8'he0, 8'h43, 8'h5a, 8'h31, 8'h37,
                            8'hf6, 8'h30, 8'h98, 8'h07, 8'ha8, 8'h8d, 8'ha2, 8'h34};
  logic [7:0] v1_k [16] = '{8'h2b, 8'h28, 8'hab, 8'h09, 8'h7e, 8'hae, 8'hf7, 8'hcf,
                            8'h15, 8'hd2, 8'h15, 8'h4f, 8'h16, 8'ha6, 8'h88, 8'h3c};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every block handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bif.out_valid) pulses.push_back(cyc);
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got block %h with empty scoreboard", bif.state_blk);
      end else begin
        blk_t e;
        e = sb.pop_front();
        check("blk_state", bif.state_blk, e.st);
        check("blk_key", bif.key_blk, e.ky);
      end
    end
  end

  // Presents one byte pair and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic [7:0] k);
    bit ok;
    ok = 1'b0;
    bif.in_valid = 1'b1;
    bif.data     = d;
    bif.key      = k;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = bif.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 for 64 cycles expected acceptance");
    end
  endtask

  task automatic send_range(input int lo, input int hi, input bit gap, input bit v6);
    for (int i = lo; i <= hi; i++) begin
      if (v6) send(8'(i), 8'(8'ha0 + i));
      else    send(v1_d[i], v1_k[i]);
      if (gap) begin
        bif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("gap_byte_cnt", bif.byte_cnt, 128'((i + 1) % 16));
      end
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic push(input logic [127:0] st, input logic [127:0] ky);
    blk_t e;
    e.st = st;
    e.ky = ky;
    sb.push_back(e);
  endtask

  initial begin
    bif.in_valid  = 1'b0;
    bif.data      = 8'h00;
    bif.key       = 8'h00;
    bif.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bif.in_ready, 1);
    check("rst_out_valid", bif.out_valid, 0);
    check("rst_state_blk", bif.state_blk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_byte_cnt", bif.byte_cnt, 0);

    // Test 1: FIPS-197 App.B vector, core not ready yet.
    push(V1_ST, V1_KY);
    send_range(0, 14, 1'b0, 1'b0);
    check("t1_cnt15", bif.byte_cnt, 15);
    check("t1_not_valid", bif.out_valid, 0);
    send_range(15, 15, 1'b0, 1'b0);
    check("t1_out_valid", bif.out_valid, 1);
    check("t1_in_ready", bif.in_ready, 0);
    check("t1_cnt0", bif.byte_cnt, 0);

    // Test 3: held block is stable and refuses new bytes.
    bif.in_valid = 1'b1;
    bif.data     = 8'hff;
    bif.key      = 8'hff;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("t3_in_ready", bif.in_ready, 0);
      check("t3_state", bif.state_blk, V1_ST);
    end
    check("t3_key", bif.key_blk, V1_KY);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_released", bif.out_valid, 0);
    check("t3_fill", bif.in_ready, 1);
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    check("t3_pos0_cnt", bif.byte_cnt, 1);
    check("t3_pos0_data", 128'(bif.state_blk[127:120]), 8'hff);
    check("t3_pos0_key", 128'(bif.key_blk[127:120]), 8'hff);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t3_clear_cnt", bif.byte_cnt, 0);

    // Test 2: one idle cycle after every byte.
    push(V1_ST, V1_KY);
    send_range(0, 15, 1'b1, 1'b0);

    // Test 4: partial block aborted by clear, which beats a pending handshake.
    send_range(0, 6, 1'b0, 1'b0);
    check("t4_cnt7", bif.byte_cnt, 7);
    clear        = 1'b1;
    bif.in_valid = 1'b1;
    bif.data     = 8'h55;
    bif.key      = 8'h55;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bif.in_valid = 1'b0;
    check("t4_clear_cnt", bif.byte_cnt, 0);
    check("t4_clear_valid", bif.out_valid, 0);
    push(V1_ST, V1_KY);
    send_range(0, 15, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Test 5: asynchronous reset in the middle of a block.
    send_range(0, 8, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", bif.in_ready, 1);
    check("t5_out_valid", bif.out_valid, 0);
    check("t5_byte_cnt", bif.byte_cnt, 0);
    check("t5_state_blk", bif.state_blk, 0);
    check("t5_key_blk", bif.key_blk, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(V1_ST, V1_KY);
    send_range(0, 15, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Test 6: two back-to-back blocks with the core always ready.
    pulses.delete();
    push(V6_ST, V6_KY);
    push(V1_ST, V1_KY);
    send_range(0, 15, 1'b0, 1'b1);
    send_range(0, 15, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) check("t6_pulse_gap", pulses[1] - pulses[0], 17);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
